// File: rtl/bf16_div.sv
// Iterative BFloat16 divider: restoring division, one quotient bit per cycle,
// round-to-nearest-even, with valid/ready handshakes on both sides.
module bf16_div #(
  parameter int E = 8,
  parameter int M = 7,
  parameter int Q = M + 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         sa_i,
  input  logic [E-1:0] ea_i,
  input  logic [M-1:0] ma_i,
  input  logic         sb_i,
  input  logic [E-1:0] eb_i,
  input  logic [M-1:0] mb_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  localparam logic [3:0] LAST = 4'(Q - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [M:0]        div_q;
  logic [M+1:0]      rem_q;
  logic [Q-1:0]      quo_q;
  logic signed [9:0] exp_q;
  logic              sgn_q;
  logic              ready_q, valid_q, s_q;
  logic [E-1:0]      e_q;
  logic [M-1:0]      m_q;

  logic a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
  logic         spec_s, spec_sgn_s;
  logic [E-1:0] spec_e_s;
  logic [M-1:0] spec_m_s;

  logic         ge_s;
  logic [M+1:0] rem_sel_s, rem_nxt_s;

  logic [M-1:0]      man_s, man_rnd_s;
  logic [M:0]        man_sum_s;
  logic              grd_s, stk_s, inc_s;
  logic signed [9:0] exp_pre_s, exp_rnd_s;
  logic [E-1:0]      res_e_s;
  logic [M-1:0]      res_m_s;

  assign a_zero_s = (ea_i == {E{1'b0}});
  assign b_zero_s = (eb_i == {E{1'b0}});
  assign a_nan_s  = (ea_i == {E{1'b1}}) && (ma_i != {M{1'b0}});
  assign b_nan_s  = (eb_i == {E{1'b1}}) && (mb_i != {M{1'b0}});
  assign a_inf_s  = (ea_i == {E{1'b1}}) && (ma_i == {M{1'b0}});
  assign b_inf_s  = (eb_i == {E{1'b1}}) && (mb_i == {M{1'b0}});

  // Special-operand result, first matching rule wins
  always_comb begin
    spec_s     = 1'b1;
    spec_sgn_s = sa_i ^ sb_i;
    spec_e_s   = {E{1'b0}};
    spec_m_s   = {M{1'b0}};
    if (a_nan_s) begin
      spec_sgn_s = sa_i;
      spec_e_s   = {E{1'b1}};
      spec_m_s   = {M{1'b1}};
    end else if (b_nan_s) begin
      spec_sgn_s = sb_i;
      spec_e_s   = {E{1'b1}};
      spec_m_s   = {M{1'b1}};
    end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
      spec_e_s = {E{1'b1}};
      spec_m_s = {M{1'b1}};
    end else if (a_inf_s || b_zero_s) begin
      spec_e_s = {E{1'b1}};
    end else if (a_zero_s || b_inf_s) begin
      spec_e_s = {E{1'b0}};
    end else begin
      spec_s = 1'b0;
    end
  end

  // One restoring-division step; the partial remainder always stays below 2*B
  always_comb begin
    ge_s = (rem_q >= {1'b0, div_q});
    if (ge_s) begin
      rem_sel_s = rem_q - {1'b0, div_q};
    end else begin
      rem_sel_s = rem_q;
    end
    rem_nxt_s = rem_sel_s << 1;
  end

  // Normalise, round to nearest even, then clamp the exponent range
  always_comb begin
    if (quo_q[Q-1]) begin
      man_s     = quo_q[Q-2:2];
      grd_s     = quo_q[1];
      stk_s     = quo_q[0] | (rem_q != {(M+2){1'b0}});
      exp_pre_s = exp_q + 10'sd1;
    end else begin
      man_s     = quo_q[Q-3:1];
      grd_s     = quo_q[0];
      stk_s     = (rem_q != {(M+2){1'b0}});
      exp_pre_s = exp_q;
    end
    inc_s     = grd_s & (stk_s | man_s[0]);
    man_sum_s = {1'b0, man_s} + {{M{1'b0}}, inc_s};
    if (man_sum_s[M]) begin
      man_rnd_s = {M{1'b0}};
      exp_rnd_s = exp_pre_s + 10'sd1;
    end else begin
      man_rnd_s = man_sum_s[M-1:0];
      exp_rnd_s = exp_pre_s;
    end
    if (exp_rnd_s >= 10'sd255) begin
      res_e_s = {E{1'b1}};
      res_m_s = {M{1'b0}};
    end else if (exp_rnd_s <= 10'sd0) begin
      res_e_s = {E{1'b0}};
      res_m_s = {M{1'b0}};
    end else begin
      res_e_s = exp_rnd_s[E-1:0];
      res_m_s = man_rnd_s;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      s_q     <= 1'b0;
      e_q     <= {E{1'b0}};
      m_q     <= {M{1'b0}};
      cnt_q   <= 4'd0;
      div_q   <= {(M+1){1'b0}};
      rem_q   <= {(M+2){1'b0}};
      quo_q   <= {Q{1'b0}};
      exp_q   <= 10'sd0;
      sgn_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            ready_q <= 1'b0;
            sgn_q   <= sa_i ^ sb_i;
            if (spec_s) begin
              s_q     <= spec_sgn_s;
              e_q     <= spec_e_s;
              m_q     <= spec_m_s;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              div_q   <= {1'b1, mb_i};
              rem_q   <= {2'b01, ma_i};
              quo_q   <= {Q{1'b0}};
              cnt_q   <= 4'd0;
              exp_q   <= $signed({2'b00, ea_i}) - $signed({2'b00, eb_i}) + 10'sd126;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          quo_q <= {quo_q[Q-2:0], ge_s};
          rem_q <= rem_nxt_s;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          s_q     <= sgn_q;
          e_q     <= res_e_s;
          m_q     <= res_m_s;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign s_o     = s_q;
  assign e_o     = e_q;
  assign m_o     = m_q;

endmodule

// File: tb/tb_bf16_div.sv
// Self-checking bench for bf16_div: directed vector table, random operands
// against an arithmetic reference model, and handshake/reset sequences.
module tb_bf16_div;

  logic       clk = 1'b0;
  logic       rst, valid_i, ready_o, ready_i, valid_o;
  logic       sa_i, sb_i, s_o;
  logic [7:0] ea_i, eb_i, e_o;
  logic [6:0] ma_i, mb_i, m_o;

  int checks = 0;
  int passed = 0;

  bf16_div dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i),
    .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .s_o(s_o), .e_o(e_o), .m_o(m_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic sa; logic [7:0] ea; logic [6:0] ma;
    logic sb; logic [7:0] eb; logic [6:0] mb;
    logic [15:0] res; int lat;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic sa, input logic [7:0] ea, input logic [6:0] ma,
                              input logic sb, input logic [7:0] eb, input logic [6:0] mb,
                              input logic s, input logic [7:0] e, input logic [6:0] m,
                              input int lat);
    vec_t v;
    v.sa = sa; v.ea = ea; v.ma = ma;
    v.sb = sb; v.eb = eb; v.mb = mb;
    v.res = {s, e, m}; v.lat = lat;
    return v;
  endfunction

  // Reference: exact integer quotient/remainder, then the rounding rules
  function automatic logic [15:0] ref_div(input logic sa, input logic [7:0] ea, input logic [6:0] ma,
                                          input logic sb, input logic [7:0] eb, input logic [6:0] mb);
    logic s;
    bit an, bn, ai, bi, az, bz;
    int num, den, q, r, man, g, st, ex;
    s  = sa ^ sb;
    an = (ea == 8'hFF) && (ma != 7'h00);
    bn = (eb == 8'hFF) && (mb != 7'h00);
    ai = (ea == 8'hFF) && (ma == 7'h00);
    bi = (eb == 8'hFF) && (mb == 7'h00);
    az = (ea == 8'h00);
    bz = (eb == 8'h00);
    if (an) return {sa, 8'hFF, 7'h7F};
    if (bn) return {sb, 8'hFF, 7'h7F};
    if ((ai && bi) || (az && bz)) return {s, 8'hFF, 7'h7F};
    if (ai || bz) return {s, 8'hFF, 7'h00};
    if (az || bi) return {s, 8'h00, 7'h00};
    num = (128 + int'(ma)) * 512;
    den = 128 + int'(mb);
    q = num / den;
    r = num % den;
    if (q >= 512) begin
      man = (q / 4) % 128;
      g   = (q / 2) % 2;
      st  = ((q % 2) != 0 || r != 0) ? 1 : 0;
      ex  = int'(ea) - int'(eb) + 127;
    end else begin
      man = (q / 2) % 128;
      g   = q % 2;
      st  = (r != 0) ? 1 : 0;
      ex  = int'(ea) - int'(eb) + 126;
    end
    if (g == 1 && (st == 1 || (man % 2) == 1)) man = man + 1;
    if (man == 128) begin
      man = 0;
      ex  = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 7'h00};
    if (ex <= 0) return {s, 8'h00, 7'h00};
    return {s, 8'(ex), 7'(man)};
  endfunction

  function automatic int ref_lat(input logic [7:0] ea, input logic [7:0] eb);
    if (ea == 8'h00 || ea == 8'hFF || eb == 8'h00 || eb == 8'hFF) return 1;
    return 12;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) begin
      passed++;
    end else begin
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Issue one operation with ready_i high; lat counts negedges from accept to valid_o
  task automatic do_op(input logic sa, input logic [7:0] ea, input logic [6:0] ma,
                       input logic sb, input logic [7:0] eb, input logic [6:0] mb,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    sa_i = sa; ea_i = ea; ma_i = ma;
    sb_i = sb; eb_i = eb; mb_i = mb;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid_o) begin
        lat = n;
        break;
      end
    end
    res = {s_o, e_o, m_o};
  endtask

  logic [15:0] res, expv, hold;
  int lat, seen;
  logic [7:0] re, rf;

  function automatic logic [7:0] rand_exp();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hFF;
    return 8'($urandom_range(1, 254));
  endfunction

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    sa_i = 1'b0; ea_i = 8'h00; ma_i = 7'h00;
    sb_i = 1'b0; eb_i = 8'h00; mb_i = 7'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_out", {s_o, e_o, m_o}, 16'h0000);
    rst = 1'b0;

    tbl[0]  = mk(0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00, 12);
    tbl[1]  = mk(0, 8'h7F, 7'h00, 0, 8'h80, 7'h40, 0, 8'h7D, 7'h2B, 12);
    tbl[2]  = mk(0, 8'h81, 7'h40, 0, 8'h80, 7'h00, 0, 8'h80, 7'h40, 12);
    tbl[3]  = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 0, 8'hFF, 7'h7F, 1);
    tbl[4]  = mk(1, 8'h7F, 7'h00, 0, 8'h00, 7'h00, 1, 8'hFF, 7'h00, 1);
    tbl[5]  = mk(0, 8'h00, 7'h00, 1, 8'h80, 7'h40, 1, 8'h00, 7'h00, 1);
    tbl[6]  = mk(0, 8'hFE, 7'h00, 0, 8'h01, 7'h00, 0, 8'hFF, 7'h00, 12);
    tbl[7]  = mk(0, 8'h01, 7'h00, 0, 8'hFE, 7'h00, 0, 8'h00, 7'h00, 12);
    tbl[8]  = mk(0, 8'h7F, 7'h00, 1, 8'hFF, 7'h01, 1, 8'hFF, 7'h7F, 1);
    tbl[9]  = mk(1, 8'hFF, 7'h00, 0, 8'hFF, 7'h00, 1, 8'hFF, 7'h7F, 1);
    tbl[10] = mk(0, 8'hFF, 7'h00, 1, 8'h80, 7'h00, 1, 8'hFF, 7'h00, 1);
    tbl[11] = mk(1, 8'h80, 7'h00, 1, 8'hFF, 7'h00, 0, 8'h00, 7'h00, 1);
    tbl[12] = mk(0, 8'h00, 7'h55, 0, 8'h7F, 7'h00, 0, 8'h00, 7'h00, 1);
    tbl[13] = mk(0, 8'h7F, 7'h00, 0, 8'h81, 7'h60, 0, 8'h7C, 7'h12, 12);
    tbl[14] = mk(1, 8'h81, 7'h40, 0, 8'h80, 7'h00, 1, 8'h80, 7'h40, 12);
    tbl[15] = mk(0, 8'h80, 7'h00, 0, 8'h80, 7'h40, 0, 8'h7E, 7'h2B, 12);

    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].sa, tbl[i].ea, tbl[i].ma, tbl[i].sb, tbl[i].eb, tbl[i].mb, res, lat);
      chk($sformatf("vec%0d_res", i), res, tbl[i].res);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    for (int i = 0; i < 10; i++) begin
      re = rand_exp();
      do_op(1'b1, 8'hFF, 7'h05, 1'($urandom), re, 7'($urandom), res, lat);
      chk("nan_a_res", res, {1'b1, 8'hFF, 7'h7F});
      chk("nan_a_lat", lat, 1);
    end

    for (int i = 0; i < 200; i++) begin
      logic ra, rb;
      logic [6:0] rma, rmb;
      ra = 1'($urandom); rb = 1'($urandom);
      re = rand_exp(); rf = rand_exp();
      rma = 7'($urandom); rmb = 7'($urandom);
      expv = ref_div(ra, re, rma, rb, rf, rmb);
      do_op(ra, re, rma, rb, rf, rmb, res, lat);
      chk("rand_res", res, expv);
      chk("rand_lat", lat, ref_lat(re, rf));
    end

    // Backpressure: result held in DONE while ready_i is low
    @(negedge clk);
    sa_i = 1'b0; ea_i = 8'h7F; ma_i = 7'h00;
    sb_i = 1'b0; eb_i = 8'h80; mb_i = 7'h40;
    valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid_o) begin
        lat = n;
        break;
      end
    end
    chk("bp_lat", lat, 12);
    hold = {s_o, e_o, m_o};
    chk("bp_res", hold, {1'b0, 8'h7D, 7'h2B});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", valid_o, 1);
      chk("bp_out_hold", {s_o, e_o, m_o}, {1'b0, 8'h7D, 7'h2B});
      chk("bp_ready_low", ready_o, 0);
      sa_i = 1'b0; ea_i = 8'hFF; ma_i = 7'h01;
      valid_i = 1'b1;
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", ready_o, 1);
    chk("bp_valid_after", valid_o, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("bp_no_capture", seen, 0);

    // Reset sampled on the fourth edge after accept
    @(negedge clk);
    sa_i = 1'b0; ea_i = 8'h7F; ma_i = 7'h00;
    sb_i = 1'b0; eb_i = 8'h7F; mb_i = 7'h00;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstdiv_valid", valid_o, 0);
    chk("rstdiv_ready", ready_o, 1);
    chk("rstdiv_out", {s_o, e_o, m_o}, 16'h0000);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("rstdiv_discard", seen, 0);
    do_op(1'b0, 8'h7F, 7'h00, 1'b0, 8'h7F, 7'h00, res, lat);
    chk("rstdiv_next_res", res, {1'b0, 8'h7F, 7'h00});
    chk("rstdiv_next_lat", lat, 12);

    // rst and valid_i on the same edge: nothing captured
    @(negedge clk);
    sa_i = 1'b0; ea_i = 8'hFF; ma_i = 7'h01;
    valid_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0;
    chk("rstvalid_ready", ready_o, 1);
    chk("rstvalid_out", {s_o, e_o, m_o}, 16'h0000);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("rstvalid_nocapture", seen, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
